// File: rtl/fpdlink_pkg.sv
// Shared constants, types and helpers for the FPD-Link I dual-pixel output packer.
package fpdlink_pkg;

  localparam int GROUP_W = 21;
  localparam int LANE_W  = 7;

  // Bit positions inside one 21-bit pixel group
  localparam int POS_G0   = 20;
  localparam int POS_R    = 14;
  localparam int POS_B_LO = 12;
  localparam int POS_G_HI = 7;
  localparam int POS_DE   = 6;
  localparam int POS_VS   = 5;
  localparam int POS_HS   = 4;
  localparam int POS_B_HI = 0;

  // 2x2 ordered-dither thresholds, entry idx at [2*idx+1:2*idx]: {0,2,3,1}
  localparam logic [7:0] BAYER_TBL = {2'd1, 2'd3, 2'd2, 2'd0};

  typedef enum logic [1:0] {ST_MUTE, ST_COUNT, ST_LIVE} mute_st_e;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb6_t;

  function automatic logic [1:0] bayer_t(input logic [1:0] idx);
    return BAYER_TBL[{idx, 1'b0} +: 2];
  endfunction

  // Scatter one pixel plus syncs into its 21-bit group
  function automatic logic [GROUP_W-1:0] pack_group(input logic de, input logic vs,
                                                    input logic hs, input rgb6_t p);
    logic [GROUP_W-1:0] g;
    g                  = '0;
    g[POS_G0]          = p.g[0];
    g[POS_R +: 6]      = p.r;
    g[POS_B_LO +: 2]   = p.b[1:0];
    g[POS_G_HI +: 5]   = p.g[5:1];
    g[POS_DE]          = de;
    g[POS_VS]          = vs;
    g[POS_HS]          = hs;
    g[POS_B_HI +: 4]   = p.b[5:2];
    return g;
  endfunction

endpackage

// File: rtl/fpdlink_dither.sv
// 8->6 bit channel reduction: add dither threshold (or 2 for rounding), saturate, drop 2 LSBs.
module fpdlink_dither (
  input  logic [7:0] c,
  input  logic [1:0] t,
  input  logic       en_dither,
  output logic [5:0] o_ch
);
  logic [1:0] w_add;
  logic [8:0] w_sum;

  assign w_add = en_dither ? t : 2'd2;
  assign w_sum = {1'b0, c} + {7'd0, w_add};
  // carry into bit 8 means the sum passed 255: clamp instead of wrapping
  assign o_ch  = w_sum[8] ? 6'h3F : w_sum[7:2];
endmodule

// File: rtl/vout_fpdlink.sv
// FPD-Link I dual-pixel packer: RGB888 x2 -> 6 lanes x 7 bits, dither, polarity, startup mute.
module vout_fpdlink
  import fpdlink_pkg::*;
#(
  parameter int         LANES       = 6,      // only 6 is meaningful
  parameter logic [5:0] CH_INVERT   = 6'b000000,
  parameter bit         DITHER      = 1'b1,
  parameter int         MUTE_FRAMES = 5       // 1..15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      link_en,
  input  logic                      v_vsync,
  input  logic                      v_hsync,
  input  logic                      v_de,
  input  logic [47:0]               v_pixel,
  output logic [LANES*LANE_W-1:0]   dout,
  output logic                      muted
);

  function automatic logic [LANES*LANE_W-1:0] f_inv_mask(input logic [5:0] inv);
    logic [LANES*LANE_W-1:0] m;
    m = '0;
    for (int k = 0; k < LANES; k++) m[k*LANE_W +: LANE_W] = {LANE_W{inv[k]}};
    return m;
  endfunction

  localparam logic [LANES*LANE_W-1:0] INV_MASK = f_inv_mask(CH_INVERT);
  localparam logic [3:0]              CNT_TGT  = 4'(MUTE_FRAMES);

  // S1 state: previous-cycle syncs/DE (also the edge-detect history) and 6-bit channels
  logic                       r_vs, r_hs, r_de;
  logic [1:0][2:0][5:0]       r_ch;     // [slot: 0 even,1 odd][0 R,1 G,2 B]
  logic                       r_fp, r_lp;
  mute_st_e                   r_state, w_state_nxt;
  logic [3:0]                 r_cnt, w_cnt_nxt;
  logic [LANES*LANE_W-1:0]    r_dout;
  logic                       r_muted;

  logic                       w_vs_rise, w_de_fall, w_live;
  logic [1:0][1:0]            w_t;
  logic [1:0][2:0][5:0]       w_ch;
  rgb6_t                      w_px_e, w_px_o;
  logic [2*GROUP_W-1:0]       w_word;

  assign w_vs_rise = v_vsync & ~r_vs;
  assign w_de_fall = ~v_de & r_de;

  // 3 channels x 2 pixels; even pixel in v_pixel[47:24], R in the top byte of each half
  for (genvar s = 0; s < 2; s++) begin : g_slot
    assign w_t[s] = bayer_t({r_lp ^ r_fp, 1'(s)});
    for (genvar k = 0; k < 3; k++) begin : g_ch
      fpdlink_dither u_dith (
        .c         (v_pixel[(1-s)*24 + (2-k)*8 +: 8]),
        .t         (w_t[s]),
        .en_dither (DITHER),
        .o_ch      (w_ch[s][k])
      );
    end
  end

  // S1 capture of syncs, DE and converted channels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs <= 1'b0;
      r_hs <= 1'b0;
      r_de <= 1'b0;
      r_ch <= '0;
    end else begin
      r_vs <= v_vsync;
      r_hs <= v_hsync;
      r_de <= v_de;
      r_ch <= w_ch;
    end
  end

  // Dither phase: frame parity per vsync, line parity per DE fall; vsync wins a tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fp <= 1'b0;
      r_lp <= 1'b0;
    end else begin
      if (w_vs_rise) r_fp <= ~r_fp;
      if (w_vs_rise)      r_lp <= 1'b0;
      else if (w_de_fall) r_lp <= ~r_lp;
    end
  end

  // Mute FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_MUTE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Mute FSM next state: count vsync edges with the link up; any link drop restarts
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_MUTE: begin
        w_cnt_nxt = '0;
        if (link_en) w_state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (!link_en) begin
          w_state_nxt = ST_MUTE;
          w_cnt_nxt   = '0;
        end else if (w_vs_rise) begin
          if (r_cnt + 4'd1 == CNT_TGT) w_state_nxt = ST_LIVE;
          else                         w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      ST_LIVE: begin
        if (!link_en) begin
          w_state_nxt = ST_MUTE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_MUTE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // S2 pack: blank DE and colour while not live, syncs always pass
  always_comb begin
    w_live = (r_state == ST_LIVE);
    w_px_e = w_live ? rgb6_t'({r_ch[0][0], r_ch[0][1], r_ch[0][2]}) : '0;
    w_px_o = w_live ? rgb6_t'({r_ch[1][0], r_ch[1][1], r_ch[1][2]}) : '0;
    w_word = {pack_group(r_de & w_live, r_vs, r_hs, w_px_o),
              pack_group(r_de & w_live, r_vs, r_hs, w_px_e)};
  end

  // S2 output register with lane polarity applied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout  <= INV_MASK;
      r_muted <= 1'b1;
    end else begin
      r_dout  <= w_word ^ INV_MASK;
      r_muted <= ~w_live;
    end
  end

  assign dout  = r_dout;
  assign muted = r_muted;

endmodule

// File: tb/tb_vout_fpdlink.sv
// Scoreboard bench: two packers (round+inverted lanes, dither+plain) on one stimulus stream.
module tb_vout_fpdlink;

  logic        clk = 1'b0, rst = 1'b1;
  logic        link_en = 1'b0, v_vsync = 1'b0, v_hsync = 1'b0, v_de = 1'b0;
  logic [47:0] v_pixel = '0;
  logic [41:0] dout0, dout1;
  logic        muted0, muted1;

  localparam logic [41:0] MASK0 = 42'h3F8_0000_007F;

  always #5 clk = ~clk;

  vout_fpdlink #(.LANES(6), .CH_INVERT(6'b100001), .DITHER(1'b0), .MUTE_FRAMES(5)) u_d0 (
    .clk(clk), .rst(rst), .link_en(link_en), .v_vsync(v_vsync), .v_hsync(v_hsync),
    .v_de(v_de), .v_pixel(v_pixel), .dout(dout0), .muted(muted0));

  vout_fpdlink #(.LANES(6), .CH_INVERT(6'b000000), .DITHER(1'b1), .MUTE_FRAMES(5)) u_d1 (
    .clk(clk), .rst(rst), .link_en(link_en), .v_vsync(v_vsync), .v_hsync(v_hsync),
    .v_de(v_de), .v_pixel(v_pixel), .dout(dout1), .muted(muted1));

  typedef struct {
    int          due;
    logic [41:0] e0, e1;
    logic        em;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   cyc = 0, nvec = 0, nbad = 0;
  bit   g_en = 1'b0;

  // reference model state
  int m_st = 0, m_cnt = 0;           // 0 mute, 1 count, 2 live
  bit m_fp = 0, m_lp = 0, m_pvs = 0, m_pde = 0;
  int tbl[4] = '{0, 2, 3, 1};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] conv(input int c, input int t);
    int v;
    v = c + t;
    if (v > 255) v = 255;
    return 6'(v / 4);
  endfunction

  function automatic logic [20:0] grp(input logic de, vs, hs, input logic [5:0] r, g, b);
    return {g[0], r, b[1:0], g[5:1], de, vs, hs, b[5:2]};
  endfunction

  function automatic logic [47:0] pat(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {b, 8'(b + 3), 8'(b * 5), 8'(b + 128), ~b, b ^ 8'h55};
  endfunction

  // drive one input cycle; expected outputs 2 cycles later go on the scoreboard
  task automatic drive(input bit en, input bit vs, input bit hs, input bit de,
                       input logic [47:0] px, input string nm,
                       input bit ov0 = 0, input logic [41:0] h0 = '0,
                       input bit ov1 = 0, input logic [41:0] h1 = '0);
    exp_t e;
    bit vsr, def, live;
    logic [5:0] c0[2][3], c1[2][3];
    @(posedge clk); #1;
    link_en = en; v_vsync = vs; v_hsync = hs; v_de = de; v_pixel = px;
    vsr = vs && !m_pvs;
    def = !de && m_pde;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 3; k++) begin
        c0[s][k] = conv(int'(px[(1-s)*24 + (2-k)*8 +: 8]), 2);
        c1[s][k] = conv(int'(px[(1-s)*24 + (2-k)*8 +: 8]), tbl[{m_lp ^ m_fp, s[0]}]);
      end
    case (m_st)
      0: if (en) m_st = 1;
      1: if (!en) m_st = 0;
         else if (vsr) begin
           if (m_cnt + 1 == 5) m_st = 2; else m_cnt++;
         end
      default: if (!en) m_st = 0;
    endcase
    if (m_st == 0) m_cnt = 0;
    live = (m_st == 2);
    if (vsr) begin m_fp = !m_fp; m_lp = 0; end
    else if (def) m_lp = !m_lp;
    m_pvs = vs; m_pde = de;
    if (!live)
      for (int s = 0; s < 2; s++)
        for (int k = 0; k < 3; k++) begin c0[s][k] = '0; c1[s][k] = '0; end
    e.due = cyc + 2;
    e.nm  = nm;
    e.em  = !live;
    e.e0  = {grp(de && live, vs, hs, c0[1][0], c0[1][1], c0[1][2]),
             grp(de && live, vs, hs, c0[0][0], c0[0][1], c0[0][2])} ^ MASK0;
    e.e1  = {grp(de && live, vs, hs, c1[1][0], c1[1][1], c1[1][2]),
             grp(de && live, vs, hs, c1[0][0], c1[0][1], c1[0][2])};
    if (ov0) e.e0 = h0;
    if (ov1) e.e1 = h1;
    sb.push_back(e);
  endtask

  // 16x4 active frame with 2-cycle vsync; raise brings link_en up on the vsync edge
  task automatic frame(input bit raise, input int seed);
    for (int i = 0; i < 3; i++) begin
      if (raise && i == 0) g_en = 1'b1;
      drive(g_en, i < 2, 1'b0, 1'b0, '0, "vblank");
    end
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 2; i++) drive(g_en, 1'b0, 1'b1, 1'b0, '0, "hsync");
      drive(g_en, 1'b0, 1'b0, 1'b0, '0, "porch");
      for (int x = 0; x < 16; x++) drive(g_en, 1'b0, 1'b0, 1'b1, pat(seed + l * 16 + x), "active");
      drive(g_en, 1'b0, 1'b0, 1'b0, '0, "porch");
    end
  endtask

  // monitor: compare every scoreboard entry when its output word is due
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      me = sb.pop_front();
      nvec++;
      if (me.due != cyc || dout0 !== me.e0 || dout1 !== me.e1 || muted0 !== me.em || muted1 !== me.em) begin
        nbad++;
        $display("FAIL %s @%0d: dout0=%h want %h dout1=%h want %h muted=%b%b want %b",
                 me.nm, cyc, dout0, me.e0, dout1, me.e1, muted0, muted1, me.em);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [41:0] w01;
    // reset pack
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++;
    if (dout0 !== MASK0 || dout1 !== 42'h0 || muted0 !== 1'b1 || muted1 !== 1'b1) begin
      nbad++;
      $display("FAIL reset: dout0=%h want %h dout1=%h want 0 muted=%b%b want 1", dout0, MASK0, dout1, muted0, muted1);
    end
    @(posedge clk); #1 rst = 1'b0;

    // link down: 100 cycles of sync/DE activity must stay muted
    for (int i = 0; i < 100; i++)
      drive(1'b0, (i % 40) < 2, (i % 10) < 2, (i % 10) >= 4, pat(i), "link_down");

    // mute release: link up on frame 1 vsync edge, live from frame 6
    for (int f = 0; f < 6; f++) frame(f == 0, f * 64);

    // packing, rounding path hand values
    drive(1'b1, 1'b0, 1'b0, 1'b1, {8'hFC, 8'h04, 8'h80, 8'h00, 8'hFC, 8'h04}, "pack",
          1'b1, {21'h101FC0, 21'h1FC048} ^ MASK0);
    // saturation on both DUTs
    drive(1'b1, 1'b0, 1'b0, 1'b1, {48{1'b1}}, "saturate",
          1'b1, {21'h1FFFCF, 21'h1FFFCF} ^ MASK0, 1'b1, {21'h1FFFCF, 21'h1FFFCF});
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, "idle");

    // dither cell: 0x01 everywhere, 2 frames x 2 lines x 2 words; the second
    // line ends with DE falling on the next vsync edge
    for (int f = 0; f < 2; f++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0, "dith_vs");
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, "dith_gap");
      for (int l = 0; l < 2; l++) begin
        for (int x = 0; x < 2; x++) begin
          w01 = (m_lp ^ m_fp) ? {21'h000040, 21'h105040} : {21'h000040, 21'h000040};
          drive(1'b1, 1'b0, 1'b0, 1'b1, {6{8'h01}}, "dither", 1'b0, '0, 1'b1, w01);
        end
        if (l == 0) drive(1'b1, 1'b0, 1'b0, 1'b0, '0, "dith_gap");
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, "idle");

    // link drop mid-line while live
    for (int x = 0; x < 3; x++) drive(1'b1, 1'b0, 1'b0, 1'b1, pat(200 + x), "pre_drop");
    g_en = 1'b0;
    for (int x = 0; x < 4; x++) drive(1'b0, 1'b0, 1'b0, 1'b1, pat(210 + x), "drop");
    // vsync edge together with link falling: must not count
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, "reup");
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, "vs_drop");
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, "down");
    g_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, "reup");
    for (int f = 0; f < 6; f++) frame(1'b0, 77 + f * 64);

    repeat (4) @(posedge clk);
    @(negedge clk);
    nvec++;
    if (sb.size() != 0) begin
      nbad++;
      $display("FAIL drain: %0d entries left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
